// File: rtl/rv_sink_responder_pkg.sv
// rv_sink_responder shared types.
// Backpressure modes, FSM states and LFSR step.
package rv_sink_pkg;

  typedef enum logic [1:0] {
    M_ALWAYS     = 2'd0,
    M_HOLD_AFTER = 2'd1,
    M_RANDOM     = 2'd2,
    M_VALID_WAIT = 2'd3
  } rv_mode_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } rv_state_e;

  // taps 16,14,13,11 seen from the right-shifting end
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/rv_sink_responder_if.sv
// Ready/valid bus between a source and a sink.
// The sink owns ready; the source owns valid and data.
interface ready_valid_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/rv_sink_responder_fifo.sv
// Capture FIFO for rv_sink_responder.
// Show-ahead head, registered empty/full.
module rv_capture_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CW-1:0]     count_nx;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count_nx = count + CW'(do_push)
                  - CW'(do_pop);
  assign head     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      empty <= (count_nx == '0);
      full  <= (count_nx == CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: rtl/rv_sink_responder.sv
// Ready/valid sink with selectable backpressure,
// beat capture, transfer count and protocol check.
module rv_sink_responder
  import rv_sink_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter int          INIT_DELAY = 3,
  parameter int          CNT_W      = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  ready_valid_if.slave      bus,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  stall_cycles,
  input  logic              cap_pop,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_empty,
  output logic              cap_full,
  output logic [31:0]       xfer_count,
  output logic              proto_err,
  input  logic              err_clear
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(INIT_DELAY + 1);

  localparam logic [1:0] S_INIT  = ST_INIT;
  localparam logic [1:0] S_ARMED = ST_ARMED;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [IW-1:0]     init_cnt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [15:0]       lfsr;
  logic              xfer;
  logic              pop_ok;
  logic              space_ok;
  logic              mode_ready;
  logic              hold_go;
  logic              ready_nx;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nx;
  logic              prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic              viol;

  assign xfer     = bus.valid && bus.ready;
  assign pop_ok   = cap_pop && !cap_empty;
  assign count_nx = fifo_count + CW'(xfer)
                  - CW'(pop_ok);
  assign space_ok = (count_nx != CW'(FIFO_DEPTH));

  always_comb begin
    mode_ready = 1'b1;
    hold_go    = 1'b0;
    unique case (1'b1)
      (mode == M_HOLD_AFTER): begin
        hold_go    = xfer && (stall_cycles != '0);
        mode_ready = !hold_go;
      end
      (mode == M_RANDOM):
        mode_ready = lfsr[0];
      (mode == M_VALID_WAIT):
        mode_ready = !xfer
                  && (bus.ready || bus.valid);
      default:
        mode_ready = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    ready_nx = 1'b0;
    unique case (1'b1)
      (state == S_INIT): begin
        if (init_cnt == IW'(INIT_DELAY - 1)) begin
          state_nx = S_ARMED;
          ready_nx = mode_ready;
        end
      end
      (state == S_ARMED): begin
        ready_nx = mode_ready;
        if (hold_go) state_nx = S_HOLD;
      end
      (state == S_HOLD): begin
        if (hold_cnt <= CNT_W'(1)) begin
          state_nx = S_ARMED;
          ready_nx = 1'b1;
        end
      end
      default:
        state_nx = S_INIT;
    endcase
    ready_nx = ready_nx && space_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      hold_cnt   <= '0;
      lfsr       <= LFSR_SEED;
      bus.ready  <= 1'b0;
      xfer_count <= '0;
    end else begin
      state     <= state_nx;
      bus.ready <= ready_nx;
      lfsr      <= lfsr_next(lfsr);
      if (state == S_INIT)
        init_cnt <= init_cnt + IW'(1);
      if (state == S_ARMED && hold_go)
        hold_cnt <= stall_cycles;
      else if (state == S_HOLD)
        hold_cnt <= hold_cnt - CNT_W'(1);
      if (xfer)
        xfer_count <= xfer_count + 32'd1;
    end
  end

  // a stalled beat must stay valid with stable data
  assign viol = (state != S_INIT) && prev_stall
             && (!bus.valid || bus.data != prev_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_data  <= '0;
      proto_err  <= 1'b0;
    end else begin
      prev_stall <= (state != S_INIT)
                 && bus.valid && !bus.ready;
      prev_data  <= bus.data;
      proto_err  <= viol || (proto_err && !err_clear);
    end
  end

  rv_capture_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (xfer),
    .pop   (cap_pop),
    .din   (bus.data),
    .head  (cap_data),
    .count (fifo_count),
    .empty (cap_empty),
    .full  (cap_full)
  );

endmodule

// File: tb/tb_rv_sink_responder.sv
// Directed + random bench for rv_sink_responder.
// Scoreboard queue and LFSR model from the rules.
module tb_rv_sink_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  stall_cycles;
  logic        cap_pop;
  logic        err_clear;
  logic [7:0]  cap_data;
  logic        cap_empty;
  logic        cap_full;
  logic [31:0] xfer_count;
  logic        proto_err;

  always #5 clk = ~clk;

  ready_valid_if #(.DATA_W(8)) bus ();

  rv_sink_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mode         (mode),
    .stall_cycles (stall_cycles),
    .cap_pop      (cap_pop),
    .cap_data     (cap_data),
    .cap_empty    (cap_empty),
    .cap_full     (cap_full),
    .xfer_count   (xfer_count),
    .proto_err    (proto_err),
    .err_clear    (err_clear)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  q [$];
  logic [31:0] mcnt;
  logic [15:0] lf;
  logic [15:0] prev;
  logic        fb;
  logic        hs;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic got,
                      input logic exp);
    chk(tag, 32'(got), 32'(exp));
  endtask

  // one clock; scoreboard follows the handshake
  task automatic step();
    logic       x;
    logic       p;
    logic [7:0] d;
    x = bus.valid && bus.ready && rst_n;
    d = bus.data;
    p = cap_pop && (q.size() != 0) && rst_n;
    if (p) chk("pop_data", 32'(cap_data), 32'(q[0]));
    @(posedge clk);
    #1;
    if (p) void'(q.pop_front());
    if (x) begin
      q.push_back(d);
      mcnt = mcnt + 32'd1;
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".cnt"}, xfer_count, mcnt);
    chk1({tag, ".empty"}, cap_empty, q.size() == 0);
    chk1({tag, ".full"}, cap_full, q.size() == 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    mode         = 2'd0;
    stall_cycles = 8'd0;
    cap_pop      = 1'b0;
    err_clear    = 1'b0;
    bus.valid    = 1'b0;
    bus.data     = 8'h00;
    mcnt         = 32'd0;

    repeat (2) step();
    chk1("rst_ready", bus.ready, 1'b0);
    chk1("rst_empty", cap_empty, 1'b1);
    chk1("rst_full", cap_full, 1'b0);
    chk("rst_data", 32'(cap_data), 32'h0);
    chk("rst_cnt", xfer_count, 32'd0);
    chk1("rst_perr", proto_err, 1'b0);

    // INIT_DELAY=3
    rst_n = 1'b1;
    step(); chk1("init1", bus.ready, 1'b0);
    step(); chk1("init2", bus.ready, 1'b0);
    step(); chk1("init3", bus.ready, 1'b1);
    chk_status("init");

    // HOLD_AFTER, stall 4
    mode = 2'd1; stall_cycles = 8'd4;
    bus.valid = 1'b1; bus.data = 8'h5A;
    step();
    bus.data = 8'hA5;
    chk1("hold_low0", bus.ready, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(); chk1("hold_low", bus.ready, 1'b0);
    end
    step(); chk1("hold_end", bus.ready, 1'b1);
    step();
    bus.valid = 1'b0;
    chk("hold_cnt", xfer_count, 32'd2);
    chk("hold_head", 32'(cap_data), 32'h5A);
    cap_pop = 1'b1;
    step();
    chk("hold_head2", 32'(cap_data), 32'hA5);
    step();
    cap_pop = 1'b0;
    chk_status("hold_pop");
    repeat (4) step();
    mode = 2'd0;
    step(); chk1("always_rdy", bus.ready, 1'b1);

    // fill to full
    for (int i = 0; i < 8; i++) begin
      bus.valid = 1'b1;
      bus.data  = 8'h80 + 8'(i);
      step();
    end
    chk1("full_rdy", bus.ready, 1'b0);
    chk1("full_flag", cap_full, 1'b1);
    chk("full_cnt", xfer_count, 32'd10);
    bus.data = 8'h88;
    step();
    chk1("full_stall", bus.ready, 1'b0);
    chk("full_cnt2", xfer_count, 32'd10);
    cap_pop = 1'b1; step(); cap_pop = 1'b0;
    chk1("pop_rdy", bus.ready, 1'b1);
    step();
    bus.valid = 1'b0;
    chk("ninth_cnt", xfer_count, 32'd11);
    chk1("ninth_full", cap_full, 1'b1);
    cap_pop = 1'b1; repeat (8) step(); cap_pop = 1'b0;
    chk_status("drain");

    // VALID_WAIT
    mode = 2'd3;
    bus.valid = 1'b1; bus.data = 8'h10;
    step();
    bus.valid = 1'b0;
    chk1("vw_fall", bus.ready, 1'b0);
    step(); chk1("vw_idle", bus.ready, 1'b0);
    bus.valid = 1'b1; bus.data = 8'h11;
    step();
    chk1("vw_rise", bus.ready, 1'b1);
    chk("vw_cnt0", xfer_count, 32'd12);
    step();
    bus.valid = 1'b0;
    chk1("vw_drop", bus.ready, 1'b0);
    chk("vw_cnt1", xfer_count, 32'd13);
    chk("vw_head", 32'(cap_data), 32'h10);
    cap_pop = 1'b1; repeat (2) step(); cap_pop = 1'b0;
    chk1("vw_perr", proto_err, 1'b0);
    chk_status("vw");

    // protocol violations during a stall
    mode = 2'd1; stall_cycles = 8'd8;
    step(); chk1("pe_rdy", bus.ready, 1'b1);
    bus.valid = 1'b1; bus.data = 8'h32;
    step();
    bus.data = 8'h33; step();
    bus.data = 8'h34; step();
    chk1("pe_set", proto_err, 1'b1);
    err_clear = 1'b1; step();
    chk1("pe_clr", proto_err, 1'b0);
    bus.data = 8'h35; step();
    chk1("pe_win", proto_err, 1'b1);
    err_clear = 1'b0; step();
    chk1("pe_sticky", proto_err, 1'b1);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk1("pe_clr2", proto_err, 1'b0);
    for (int i = 0; i < 20 && !bus.ready; i++) step();
    chk1("pe_wait_rdy", bus.ready, 1'b1);
    step();
    bus.valid = 1'b0;
    repeat (8) step();
    stall_cycles = 8'd6;
    bus.valid = 1'b1; bus.data = 8'h36;
    for (int i = 0; i < 20 && !bus.ready; i++) step();
    step();
    bus.valid = 1'b0;
    chk_status("pre_rst");
    chk("pre_rst_n", 32'(q.size()), 32'd3);
    step(); chk1("mid_hold", bus.ready, 1'b0);

    // async reset mid-HOLD
    rst_n = 1'b0;
    #1;
    chk1("ar_ready", bus.ready, 1'b0);
    chk1("ar_empty", cap_empty, 1'b1);
    chk1("ar_full", cap_full, 1'b0);
    chk("ar_cnt", xfer_count, 32'd0);
    q.delete();
    mcnt = 32'd0;
    mode = 2'd2;
    repeat (2) step();
    rst_n = 1'b1;

    // RANDOM mode vs LFSR sequence
    lf = 16'hACE1;
    for (int k = 1; k <= 40; k++) begin
      prev = lf;
      step();
      fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
      lf = (lf >> 1) | (16'(fb) << 15);
      chk1("lfsr_rdy", bus.ready,
           (k >= 3) ? prev[0] : 1'b0);
    end

    // random traffic, protocol-compliant source
    for (int n = 0; n < 400; n++) begin
      if (!bus.valid && $urandom_range(0, 1) == 1) begin
        bus.valid = 1'b1;
        bus.data  = 8'($urandom);
      end
      cap_pop = ($urandom_range(0, 7)
                 < ((n < 200) ? 1 : 4));
      if ($urandom_range(0, 15) == 0)
        mode = 2'($urandom_range(0, 3));
      stall_cycles = 8'($urandom_range(0, 3));
      hs = bus.valid && bus.ready;
      step();
      if (hs) begin
        if ($urandom_range(0, 1) == 1)
          bus.data = 8'($urandom);
        else
          bus.valid = 1'b0;
      end
      chk_status("rnd");
      chk1("rnd_perr", proto_err, 1'b0);
      if (q.size() == 8)
        chk1("rnd_gate", bus.ready, 1'b0);
    end
    cap_pop = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
